// File: rtl/data_stack.sv
// +--------------------------------------------------------------------------+
// | Module   : data_stack                                                    |
// | Purpose  : Stack with TOS/NOS registers and a DEPTH-entry spill RAM.     |
// |            Optional guard logic: define DSTACK_GUARD_EN.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module data_stack #(
  parameter int DEPTH = 16,
  parameter int DSZ   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                op,
  input  logic [DSZ-1:0]            vi,
  output logic [DSZ-1:0]            s0,
  output logic [DSZ-1:0]            s1,
  output logic [$clog2(DEPTH)+1:0]  depth,
  output logic                      empty,
  output logic                      full,
  output logic                      ovf,
  output logic                      unf
);

  localparam int CAP = DEPTH + 2;
  localparam int AW  = $clog2(DEPTH);
  localparam int DW  = AW + 2;

  localparam logic [1:0]    c_OP_PUSH = 2'b01;
  localparam logic [1:0]    c_OP_POP  = 2'b10;
  localparam logic [1:0]    c_OP_PICK = 2'b11;
  localparam logic [DW-1:0] c_D2      = DW'(2);
  localparam logic [DW-1:0] c_D3      = DW'(3);
  localparam logic [DW-1:0] c_DCAP    = DW'(CAP);
  localparam logic [AW:0]   c_SP1     = (AW+1)'(1);

  logic [DSZ-1:0] r_mem [DEPTH];
  logic [DSZ-1:0] r_s0;
  logic [DSZ-1:0] r_s1;
  logic [DW-1:0]  r_depth;
  // Spill pointer reaches DEPTH when full, so it carries one bit beyond the RAM address
  logic [AW:0]    r_sp;
  logic           r_ovf;
  logic           r_unf;

  logic [AW:0]    w_n;
  logic [AW:0]    w_pick_idx;
  logic [AW:0]    w_pop_idx;
  logic [DSZ-1:0] w_pick_val;
  logic [DSZ-1:0] w_push_val;
  logic [DSZ-1:0] w_pop_s1;
  logic           w_is_push;
  logic           w_ovf_err;
  logic           w_unf_err;
  logic           w_push_go;
  logic           w_pop_go;

  assign w_n        = vi[AW:0];
  assign w_pick_idx = r_sp + c_SP1 - w_n;
  assign w_pop_idx  = r_sp - c_SP1;
  assign w_is_push  = (op == c_OP_PUSH) || (op == c_OP_PICK);

  always_comb begin
    w_pick_val = r_mem[w_pick_idx[AW-1:0]];
    if (w_n == '0)
      w_pick_val = r_s0;
    else if (w_n == c_SP1)
      w_pick_val = r_s1;
  end

  assign w_push_val = (op == c_OP_PICK) ? w_pick_val : vi;
  assign w_pop_s1   = (r_depth >= c_D3) ? r_mem[w_pop_idx[AW-1:0]] : '0;

`ifdef DSTACK_GUARD_EN
  assign w_ovf_err = w_is_push && full;
  assign w_unf_err = ((op == c_OP_POP) && empty) ||
                     ((op == c_OP_PICK) && ({1'b0, w_n} >= r_depth));
`else
  assign w_ovf_err = 1'b0;
  assign w_unf_err = 1'b0;
`endif

  assign w_push_go = w_is_push && !w_ovf_err && !w_unf_err;
  assign w_pop_go  = (op == c_OP_POP) && !w_unf_err;

  // RAM is not reset; rst_n only gates the write so an aborted op leaves no trace
  always_ff @(posedge clk) begin
    if (rst_n && w_push_go && (r_depth >= c_D2))
      r_mem[r_sp[AW-1:0]] <= r_s1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0    <= '0;
      r_s1    <= '0;
      r_depth <= '0;
      r_sp    <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_ovf_err) r_ovf <= 1'b1;
      if (w_unf_err) r_unf <= 1'b1;
      if (w_push_go) begin
        r_s1    <= r_s0;
        r_s0    <= w_push_val;
        r_depth <= r_depth + 1'b1;
        if (r_depth >= c_D2) r_sp <= r_sp + c_SP1;
      end else if (w_pop_go) begin
        r_s0    <= r_s1;
        r_s1    <= w_pop_s1;
        r_depth <= r_depth - 1'b1;
        if (r_depth >= c_D3) r_sp <= r_sp - c_SP1;
      end
    end
  end

  assign s0    = r_s0;
  assign s1    = r_s1;
  assign depth = r_depth;
  assign empty = (r_depth == '0);
  assign full  = (r_depth == c_DCAP);
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

`default_nettype wire
